// File: rtl/rx_deserializer_unstripe.sv
// ------------------------------------------------------------------------
// rx_deserializer_unstripe : comma-aligned serial Rx with round-robin unstripe
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module rx_deserializer_unstripe #(
  parameter int              WIDTH       = 8,
  parameter int              LANES       = 4,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
  parameter int              COMMA_COUNT = 4,
  parameter int              LOSS_COUNT  = 16
) (
  input  logic                   clk_32f,
  input  logic                   rst,
  input  logic                   serial_in,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   locked,
  output logic                   sym_err
);

  localparam int BCW = $clog2(WIDTH);
  localparam int CCW = $clog2(COMMA_COUNT + 1);
  localparam int LCW = (LOSS_COUNT > 0) ? $clog2(LOSS_COUNT + 1) : 1;
  localparam int LPW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr;
  logic [BCW-1:0]   bit_cnt, bit_cnt_n;
  logic [CCW-1:0]   comma_cnt, comma_cnt_n;
  logic [LPW-1:0]   lane_ptr, lane_ptr_n;
  logic [LCW-1:0]   loss_cnt, loss_cnt_n;
  logic [LANES-1:0] valid_n;
  logic             err_n;

  logic [WIDTH-1:0] nxt;
  logic             tick;
  logic             is_comma;
  logic             is_idle;
  logic [CCW-1:0]   comma_inc;
  logic [LCW-1:0]   loss_inc;
  logic [LPW-1:0]   lane_ptr_inc;

  assign nxt          = {sr[WIDTH-2:0], serial_in};
  assign tick         = (bit_cnt == BCW'(WIDTH - 1));
  assign is_comma     = (nxt == COMMA);
  assign is_idle      = (nxt == IDLE);
  assign comma_inc    = comma_cnt + CCW'(1);
  assign loss_inc     = loss_cnt + LCW'(1);
  assign lane_ptr_inc = (lane_ptr == LPW'(LANES - 1)) ? '0 : lane_ptr + LPW'(1);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = tick ? '0 : bit_cnt + BCW'(1);
    comma_cnt_n = comma_cnt;
    lane_ptr_n  = lane_ptr;
    loss_cnt_n  = loss_cnt;
    valid_n     = '0;
    err_n       = 1'b0;

    case (state)
      SEARCH: begin
        // Bit-granular hunt: the comma's last bit fixes the symbol boundary.
        bit_cnt_n = '0;
        if (is_comma) begin
          comma_cnt_n = CCW'(1);
          lane_ptr_n  = '0;
          loss_cnt_n  = '0;
          state_n     = (COMMA_COUNT == 1) ? LOCKED : ALIGN;
        end
      end

      ALIGN: begin
        if (tick) begin
          if (is_comma) begin
            comma_cnt_n = comma_inc;
            if (comma_inc == CCW'(COMMA_COUNT)) begin
              state_n    = LOCKED;
              lane_ptr_n = '0;
              loss_cnt_n = '0;
            end
          end else begin
            err_n       = 1'b1;
            comma_cnt_n = '0;
            state_n     = SEARCH;
          end
        end
      end

      LOCKED: begin
        if (tick) begin
          if (is_comma) begin
            lane_ptr_n = '0;
            loss_cnt_n = '0;
          end else begin
            loss_cnt_n = loss_inc;
            if (!is_idle) begin
              valid_n[lane_ptr] = 1'b1;
              lane_ptr_n        = lane_ptr_inc;
            end
            // The symbol that exhausts the budget is still forwarded above.
            if ((LOSS_COUNT != 0) && (loss_inc == LCW'(LOSS_COUNT))) begin
              state_n     = SEARCH;
              err_n       = 1'b1;
              comma_cnt_n = '0;
            end
          end
        end
      end

      default: begin
        state_n = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      lane_ptr  <= '0;
      loss_cnt  <= '0;
      valid_out <= '0;
      locked    <= 1'b0;
      sym_err   <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= nxt;
      bit_cnt   <= bit_cnt_n;
      comma_cnt <= comma_cnt_n;
      lane_ptr  <= lane_ptr_n;
      loss_cnt  <= loss_cnt_n;
      valid_out <= valid_n;
      locked    <= (state_n == LOCKED);
      sym_err   <= err_n;
    end
  end

  // Lanes hold their last value until the round-robin pointer writes them again.
  logic [WIDTH-1:0] lane_q [LANES];

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      always_ff @(posedge clk_32f) begin
        if (rst) begin
          lane_q[k] <= '0;
        end else if (valid_n[k]) begin
          lane_q[k] <= nxt;
        end
      end
      assign data_out[k*WIDTH +: WIDTH] = lane_q[k];
    end
  endgenerate

endmodule

`default_nettype wire
